// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter for an RV32I core: arbitrates IF fetches and MEM-stage
// data accesses onto one memory port with data priority and a fetch starvation override.
module rv32i_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [29:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic [29:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW    = 30;
    localparam int unsigned DW    = 32;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_DM = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starve_hit;

    // Grant selection and memory port mux; reset suppresses all grants.
    always_comb begin
        w_starve_hit = (r_starve_cnt == LIMIT);
        if_gnt       = 1'b0;
        dm_gnt       = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_wdata    = '0;
        if (!reset) begin
            if (if_req && (w_starve_hit || !dm_req)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
        if (if_gnt) begin
            mem_addr  = if_addr;
            mem_be    = 4'hF;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_wdata = dm_wdata;
        end
        stall_if = if_req & ~if_gnt;
    end

    // Counts consecutive refused fetch cycles, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every grant is independent of the outstanding response: fully pipelined.
    always_comb begin
        w_next_state = IDLE;
        if (if_gnt) begin
            w_next_state = RESP_IF;
        end else if (dm_gnt && !dm_we) begin
            w_next_state = RESP_DM;
        end
    end

    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        case (r_state)
            RESP_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = DW'(mem_rdata);
            end
            RESP_DM: begin
                dm_rvalid = 1'b1;
                dm_rdata  = DW'(mem_rdata);
            end
            default: ;
        endcase
    end

    logic [AW-1:0] w_unused_aw;
    assign w_unused_aw = '0;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a one-cycle-latency memory model.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [29:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [29:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;

    int vectors     = 0;
    int miscompares = 0;

    rv32i_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if)
    );

    always #5 clk = ~clk;

    // Memory returns an address-derived pattern one cycle after the address.
    always_ff @(posedge clk) mem_rdata <= {2'b00, mem_addr} ^ 32'hC0DE_0000;

    function automatic logic [31:0] rd(input logic [29:0] a);
        return {2'b00, a} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        if_req = 1'b1; if_addr = 30'h5; dm_req = 1'b1; dm_addr = 30'h6; dm_be = 4'hF;
        tick();
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();

        // Fetch-only stream, addresses 0,1,2 back-to-back
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1; if_addr = 30'(i);
            #1;
            chk("fetch_gnt", 32'(if_gnt), 32'd1);
            chk("fetch_mem_addr", 32'(mem_addr), 32'(i));
            chk("fetch_mem_be", 32'(mem_be), 32'hF);
            chk("fetch_mem_we", 32'(mem_we), 32'd0);
            chk("fetch_stall", 32'(stall_if), 32'd0);
            tick();
            chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
            chk("fetch_rdata", if_rdata, rd(30'(i)));
            chk("fetch_dm_rvalid", 32'(dm_rvalid), 32'd0);
        end

        // Contention: data wins, fetch stalls
        if_req = 1'b1; if_addr = 30'h5;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h40; dm_be = 4'hF;
        #1;
        chk("cont_dm_gnt", 32'(dm_gnt), 32'd1);
        chk("cont_if_gnt", 32'(if_gnt), 32'd0);
        chk("cont_mem_addr", 32'(mem_addr), 32'h40);
        chk("cont_stall", 32'(stall_if), 32'd1);
        tick();
        chk("cont_dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("cont_dm_rdata", dm_rdata, rd(30'h40));
        chk("cont_if_rvalid", 32'(if_rvalid), 32'd0);
        idle_inputs();
        #1;
        chk("nogrant_mem_addr", 32'(mem_addr), 32'd0);
        chk("nogrant_mem_be", 32'(mem_be), 32'd0);
        chk("nogrant_mem_wdata", mem_wdata, 32'd0);
        tick();

        // Starvation: fetch forced through on the fifth contended cycle
        if_req = 1'b1; if_addr = 30'h7;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h10; dm_be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("starve_dm_gnt", 32'(dm_gnt), (i == 4) ? 32'd0 : 32'd1);
            chk("starve_if_gnt", 32'(if_gnt), (i == 4) ? 32'd1 : 32'd0);
            chk("starve_mem_addr", 32'(mem_addr), (i == 4) ? 32'h7 : 32'h10);
            tick();
            chk("starve_if_rvalid", 32'(if_rvalid), (i == 4) ? 32'd1 : 32'd0);
            chk("starve_dm_rvalid", 32'(dm_rvalid), (i == 4) ? 32'd0 : 32'd1);
            chk("starve_rdata", (i == 4) ? if_rdata : dm_rdata, (i == 4) ? rd(30'h7) : rd(30'h10));
        end
        idle_inputs();
        tick();

        // Store: passes through, no read response
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 30'h22; dm_wdata = 32'hDEAD_BEEF;
        #1;
        chk("st_dm_gnt", 32'(dm_gnt), 32'd1);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_be", 32'(mem_be), 32'h3);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_addr", 32'(mem_addr), 32'h22);
        tick();
        idle_inputs();
        chk("st_no_rvalid", 32'(dm_rvalid), 32'd0);
        chk("st_no_rdata", dm_rdata, 32'd0);
        tick();

        // Reset while a load response is outstanding
        dm_req = 1'b1; dm_addr = 30'h33; dm_be = 4'hF;
        tick();
        dm_addr = 30'h34;
        chk("rstmid_rvalid_pre", 32'(dm_rvalid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_rvalid_async", 32'(dm_rvalid), 32'd0);
        chk("rstmid_rdata_async", dm_rdata, 32'd0);
        chk("rstmid_dm_gnt", 32'(dm_gnt), 32'd0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
        chk("rstmid_post_dm_rvalid", 32'(dm_rvalid), 32'd0);
        chk("rstmid_post_if_rvalid", 32'(if_rvalid), 32'd0);

        // Alternation: load, fetch, load
        dm_req = 1'b1; dm_addr = 30'h50; dm_be = 4'hF;
        #1;
        chk("alt0_dm_gnt", 32'(dm_gnt), 32'd1);
        tick();
        chk("alt0_dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("alt0_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("alt0_rdata", dm_rdata, rd(30'h50));
        idle_inputs();
        if_req = 1'b1; if_addr = 30'h9;
        #1;
        chk("alt1_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        chk("alt1_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("alt1_dm_rvalid", 32'(dm_rvalid), 32'd0);
        chk("alt1_rdata", if_rdata, rd(30'h9));
        idle_inputs();
        dm_req = 1'b1; dm_addr = 30'h51; dm_be = 4'hF;
        #1;
        chk("alt2_dm_gnt", 32'(dm_gnt), 32'd1);
        tick();
        chk("alt2_dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("alt2_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("alt2_rdata", dm_rdata, rd(30'h51));
        idle_inputs();
        tick();
        chk("final_idle", 32'({if_rvalid, dm_rvalid}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles fetch may be refused before it takes priority (legal range 1-15).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch request (IF stage).
REQ-005 if_addr  input  30  fetch word address [31:2].
REQ-006 if_gnt  output  1  fetch granted this cycle.
REQ-007 if_rvalid  output  1  fetch read data valid.
REQ-008 if_rdata  output  32  fetch read data (instruction word).
REQ-009 dm_req  input  1  data-memory request (MEM stage).
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_be  input  4  store byte enables.
REQ-012 dm_addr  input  30  data word address [31:2].
REQ-013 dm_wdata  input  32  store data.
REQ-014 dm_gnt  output  1  data request granted this cycle.
REQ-015 dm_rvalid  output  1  load data valid.
REQ-016 dm_rdata  output  32  load data.
REQ-017 mem_addr  output  30  word address to the memory interface.
REQ-018 mem_we  output  1  memory write strobe.
REQ-019 mem_be  output  4  memory byte enables.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  memory read data, registered inside memory and valid the cycle after the address.
REQ-022 stall_if  output  1  high when if_req is high and if_gnt is low.

Function
REQ-023 At most one of if_gnt and dm_gnt SHALL be high in any cycle; the grant is combinational from the requests, starve_cnt and state.
REQ-024 Default priority: data over fetch; if dm_req is high, dm_gnt = 1.
REQ-025 Starvation override: when starve_cnt == STARVE_LIMIT and if_req is high, fetch is granted and dm_gnt = 0.
REQ-026 starve_cnt (4 bits): increments when if_req = 1 and if_gnt = 0; clears when if_gnt = 1 or if_req = 0; saturates at STARVE_LIMIT.
REQ-027 Granted requester drives mem_*. On fetch grant: mem_addr = if_addr, mem_we = 0, mem_be = 4'hF, mem_wdata = 0. On data grant: dm_* fields are passed through, with mem_we = dm_we.
REQ-028 No grant: mem_addr = 0, mem_we = 0, mem_be = 0, mem_wdata = 0.
REQ-029 Response FSM states, registered:
- IDLE: no read outstanding.
- RESP_IF: fetch read returns this cycle.
- RESP_DM: load returns this cycle.
REQ-030 Next state, from any state:
- RESP_IF if if_gnt;
- RESP_DM if dm_gnt and !dm_we;
- otherwise IDLE.
The arbiter is fully pipelined: a new grant is legal in every state, back-to-back.
REQ-031 In RESP_IF: if_rvalid = 1 and if_rdata = mem_rdata. Otherwise if_rvalid = 0 and if_rdata = 0.
REQ-032 In RESP_DM: dm_rvalid = 1 and dm_rdata = mem_rdata. Otherwise dm_rvalid = 0 and dm_rdata = 0.
REQ-033 Read latency is exactly 1 cycle from grant to rvalid; a store completes at grant and produces no rvalid.
REQ-034 Requesters hold req and address stable until granted; requests are not queued, so an ungranted request is simply re-arbitrated next cycle.
REQ-035 Simultaneous requests at starve_cnt < STARVE_LIMIT: data wins and starve_cnt increments.
REQ-036 stall_if SHALL equal if_req & !if_gnt.

Reset
REQ-037 While reset is high, the block SHALL asynchronously force state = IDLE and starve_cnt = 0, and hence all rvalid/rdata outputs to 0.
REQ-038 Reset asserted with a read outstanding drops that response; no rvalid is issued after reset deasserts.
REQ-039 While reset is high, grants SHALL be 0 and mem_* SHALL take the no-grant values.

Verification
REQ-040 Fetch only: if_req = 1, if_addr = 0,1,2 on consecutive cycles -> if_gnt = 1 each cycle; mem_addr follows the addresses; if_rvalid = 1 one cycle later with if_rdata = mem_rdata each cycle.
REQ-041 Contention: if_req = dm_req = 1 with load dm_addr = 0x40 -> dm_gnt = 1, mem_addr = 0x40, stall_if = 1; next cycle dm_rvalid = 1.
REQ-042 Starvation: if_req held, dm_req held for 6 cycles, STARVE_LIMIT = 4 -> dm_gnt for cycles 0-3, if_gnt in cycle 4, starve_cnt cleared, dm_gnt again in cycle 5.
REQ-043 Store: dm_req = 1, dm_we = 1, dm_be = 4'b0011, dm_wdata = 0xDEADBEEF -> mem_we = 1, mem_be = 4'b0011, mem_wdata = 0xDEADBEEF; no dm_rvalid follows.
REQ-044 Reset mid-read: load granted, reset asserted before the next clock edge -> dm_rvalid = 0 immediately; state IDLE after reset release.
REQ-045 Back-to-back alternation: data load, fetch, data load -> rvalid pattern dm, if, dm with correct routing and no overlap.
